lane_move_sched: RTL and testbench
==================================

Name: lane_move_sched

Overview:
- Sequences player lane changes for the 3-lane game.
- Converts raw left/right button levels into edge-detected move requests and buffers them in a small FIFO.
- Issues at most one lane change per game tick, then enforces a hold-off of HOLD_TICKS ticks.
- Owns the authoritative lane register that the renderer and collision logic read.

Parameters:
QDEPTH, 4, pending-move FIFO depth; power of two, 2..16
HOLD_TICKS, 1, ticks ignored after a move before the next pop; 0 disables hold-off
CW, 4, width of the hold-off counter; must hold HOLD_TICKS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_left  in  1  left button level, already synchronised to clk
btn_right  in  1  right button level, already synchronised to clk
tick  in  1  one-cycle game tick strobe
game_en  in  1  high while a game is running
lane  out  2  current lane: 00 OFF, 01 LEFT, 10 MIDDLE, 11 RIGHT
move_valid  out  1  one-cycle pulse when lane changes
move_dir  out  1  direction of the last move: 0 left, 1 right
q_count  out  $clog2(QDEPTH)+1  pending moves in FIFO
q_full  out  1  q_count == QDEPTH
overflow  out  1  sticky: a request was dropped because FIFO full

Behaviour:
- Reset (async, rst_n low): lane=OFF, move_valid=0, move_dir=0, q_count=0, overflow=0, FSM=OFF, edge registers=0, hold counter=0.
- Edge detect: request L when btn_left is 1 now and was 0 last cycle; R likewise for btn_right.
  - L and R in the same cycle: both discarded.
  - Requests are ignored in state OFF.
- FIFO push: an accepted request is written on the cycle after its edge (1-cycle latency to q_count).
  - Push when full: dropped, overflow<=1.
  - Simultaneous push and pop when full: both happen; no overflow.
- FSM states: OFF, RUN, HOLD.
  - OFF: lane=OFF; FIFO flushed; when game_en=1 -> RUN next cycle with lane=MIDDLE, overflow cleared.
  - RUN: on tick=1 with q_count>0, pop the head entry.
    - Next edge: apply the move to lane, set move_dir to the entry's direction, pulse move_valid for exactly 1 cycle.
    - If HOLD_TICKS>0, go to HOLD with counter=HOLD_TICKS.
    - tick with empty FIFO: no action.
  - HOLD: each tick decrements the counter; when the counter reaches 0 on a tick, go to RUN. The FIFO still accepts pushes; no pops occur.
  - Any state, game_en=0: -> OFF next cycle. This is a mid-move abort: the FIFO is flushed and move_valid is forced to 0.
- Lane arithmetic: left from MIDDLE->LEFT, left from RIGHT->MIDDLE, right mirrors this.
  - Left at LEFT or right at RIGHT (saturation): entry is consumed, lane is unchanged, no move_valid pulse, HOLD is not entered.
- Pointers wrap modulo QDEPTH; q_count never exceeds QDEPTH.

Optional Feature:
- Macro LANE_WRAP_EN.
- Defined: moves wrap around the lanes. Left at LEFT -> RIGHT, right at RIGHT -> LEFT; these count as real moves (move_valid pulses, HOLD is entered).
- Undefined: saturating behaviour as described in Behaviour.

Decomposition:
- Shared package lane_pkg holds:
  - lane encoding constants LANE_OFF/LANE_LEFT/LANE_MIDDLE/LANE_RIGHT;
  - typedef lane_t (2 bits);
  - DIR_LEFT/DIR_RIGHT constants;
  - FSM state enum sched_state_t.
- One sub-module, move_fifo: a 1-bit-wide synchronous FIFO, parameterised by QDEPTH, exposing push/pop/count/full. Edge detect, FSM and lane update stay in the top.

Test Plan:
- Reset, then game_en=1 -> lane=10 one cycle later; q_count=0; overflow=0.
- HOLD_TICKS=1; press left, two ticks apart then press right -> left pops on tick 1 (lane 01, move_valid 1 cycle, move_dir 0); tick 2 is consumed by HOLD; tick 3 gives lane 10, move_dir 1.
- Five left presses with no tick, QDEPTH=4 -> q_count=4, q_full=1, overflow=1; subsequent ticks take lane to 01 and leave it there, with only 1 move_valid pulse (saturation).
- btn_left and btn_right rise in the same cycle -> q_count stays 0.
- Two moves queued, game_en dropped during HOLD -> next cycle lane=00, q_count=0, FSM OFF; later presses are ignored.
- With LANE_WRAP_EN, lane=01 plus a left press and tick -> lane=11, move_valid pulses, move_dir=0.

Source files
------------

// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - lane encodings, direction constants, scheduler states and lane-move arithmetic.
package lane_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_OFF    = 2'b00;
  localparam lane_t LANE_LEFT   = 2'b01;
  localparam lane_t LANE_MIDDLE = 2'b10;
  localparam lane_t LANE_RIGHT  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_t;

  // Edge lanes either saturate or wrap to the opposite edge depending on wrap_en.
  function automatic lane_t apply_move(input lane_t cur, input logic dir, input logic wrap_en);
    lane_t nxt;
    nxt = cur;
    case (cur)
      LANE_LEFT:   nxt = (dir == DIR_RIGHT) ? LANE_MIDDLE : (wrap_en ? LANE_RIGHT : LANE_LEFT);
      LANE_MIDDLE: nxt = (dir == DIR_RIGHT) ? LANE_RIGHT : LANE_LEFT;
      LANE_RIGHT:  nxt = (dir == DIR_RIGHT) ? (wrap_en ? LANE_LEFT : LANE_RIGHT) : LANE_MIDDLE;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - 1-bit-wide synchronous FIFO of pending move directions with flush.
module move_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     push_data_i,
  input  logic                     pop_i,
  output logic                     pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/lane_move_sched.sv
// rtl/lane_move_sched.sv - button edge detect, move queue and per-tick lane scheduler.
// Define LANE_WRAP_EN to make edge-lane moves wrap to the opposite lane instead of saturating.
module lane_move_sched
  import lane_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int HOLD_TICKS = 1,
  parameter int CW         = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      tick,
  input  logic                      game_en,
  output logic [1:0]                lane,
  output logic                      move_valid,
  output logic                      move_dir,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      q_full,
  output logic                      overflow
);

`ifdef LANE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  sched_state_t  state_q, state_d;
  lane_t         lane_q, lane_d, moved_lane;
  logic          left_q, right_q;
  logic          dir_q, dir_d, mv_q, mv_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_l, req_r, flush, push, pop, head_dir;

  assign req_l = btn_left && !left_q;
  assign req_r = btn_right && !right_q;

  // Dropping game_en flushes in the same cycle so the abort is visible one cycle later.
  assign flush      = (state_q == ST_OFF) || !game_en;
  assign push       = (req_l ^ req_r) && !flush;
  assign pop        = (state_q == ST_RUN) && tick && (q_count != '0) && !flush;
  assign moved_lane = apply_move(lane_q, head_dir, WRAP);

  move_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (req_r),
    .pop_i       (pop),
    .pop_data_o  (head_dir),
    .count_o     (q_count),
    .full_o      (q_full)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    dir_d   = dir_q;
    mv_d    = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q || (push && q_full && !pop);
    if (!game_en) begin
      state_d = ST_OFF;
      lane_d  = LANE_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_RUN;
          lane_d  = LANE_MIDDLE;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
        ST_RUN: begin
          // A saturated move consumes the entry without pulsing or holding off.
          if (pop && (moved_lane != lane_q)) begin
            lane_d = moved_lane;
            dir_d  = head_dir;
            mv_d   = 1'b1;
            if (HOLD_TICKS > 0) begin
              state_d = ST_HOLD;
              cnt_d   = CW'(HOLD_TICKS);
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (cnt_q <= CW'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      lane_q  <= LANE_OFF;
      dir_q   <= DIR_LEFT;
      mv_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      dir_q   <= dir_d;
      mv_q    <= mv_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      left_q  <= btn_left;
      right_q <= btn_right;
    end
  end

  assign lane       = lane_q;
  assign move_valid = mv_q;
  assign move_dir   = dir_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_lane_move_sched.sv
// tb/tb_lane_move_sched.sv - directed scoreboard bench for lane_move_sched (QDEPTH=4, HOLD_TICKS=1).
module tb_lane_move_sched;

  logic       clk = 1'b0;
  logic       rst_n, btn_left, btn_right, tick, game_en;
  logic [1:0] lane;
  logic       move_valid, move_dir, q_full, overflow;
  logic [2:0] q_count;

  int         vectors = 0;
  int         miscompares = 0;
  int         pulses = 0;
  int         exp_pulses = 0;
  logic [2:0] sb[$];
  logic [2:0] e_mv;

  lane_move_sched #(.QDEPTH(4), .HOLD_TICKS(1), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .tick       (tick),
    .game_en    (game_en),
    .lane       (lane),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .q_count    (q_count),
    .q_full     (q_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_left();
    btn_left = 1'b1;
    cyc();
    btn_left = 1'b0;
    cyc();
  endtask

  task automatic press_right();
    btn_right = 1'b1;
    cyc();
    btn_right = 1'b0;
    cyc();
  endtask

  // One-cycle tick; when a move is expected its lane/direction goes to the scoreboard.
  task automatic do_tick(input logic mv, input logic [1:0] l, input logic d);
    if (mv) begin
      sb.push_back({l, d});
      exp_pulses++;
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("tick_move_valid", 32'(move_valid), 32'(mv));
    cyc();
    chk("pulse_width", 32'(move_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && move_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("move_unexpected", 32'd1, 32'd0);
      end else begin
        e_mv = sb.pop_front();
        chk("move_lane", 32'(lane), 32'(e_mv[2:1]));
        chk("move_dir", 32'(move_dir), 32'(e_mv[0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn_left = 1'b0; btn_right = 1'b0; tick = 1'b0; game_en = 1'b0;
    cyc(); cyc();
    chk("rst_lane", 32'(lane), 32'd0);
    chk("rst_move_valid", 32'(move_valid), 32'd0);
    chk("rst_move_dir", 32'(move_dir), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("off_lane", 32'(lane), 32'd0);

    game_en = 1'b1;
    cyc();
    chk("en_lane", 32'(lane), 32'd2);
    chk("en_q_count", 32'(q_count), 32'd0);
    chk("en_overflow", 32'(overflow), 32'd0);

    // left then right with HOLD_TICKS=1: second tick is swallowed by the hold-off
    press_left();
    chk("push_latency", 32'(q_count), 32'd1);
    press_right();
    chk("two_queued", 32'(q_count), 32'd2);
    do_tick(1'b1, 2'b01, 1'b0);
    chk("after_t1_lane", 32'(lane), 32'd1);
    chk("after_t1_q", 32'(q_count), 32'd1);
    do_tick(1'b0, 2'b00, 1'b0);
    chk("hold_lane", 32'(lane), 32'd1);
    chk("hold_q", 32'(q_count), 32'd1);
    do_tick(1'b1, 2'b10, 1'b1);
    chk("after_t3_lane", 32'(lane), 32'd2);
    chk("after_t3_q", 32'(q_count), 32'd0);
    do_tick(1'b0, 2'b00, 1'b0);

    // five lefts into a 4-deep FIFO, then drain with saturation at LEFT
    for (int i = 0; i < 5; i++) press_left();
    chk("ovf_q_count", 32'(q_count), 32'd4);
    chk("ovf_q_full", 32'(q_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    do_tick(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) do_tick(1'b0, 2'b00, 1'b0);
    chk("sat_lane", 32'(lane), 32'd1);
    chk("sat_q_count", 32'(q_count), 32'd0);
    chk("sat_q_full", 32'(q_full), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // simultaneous edges cancel
    btn_left = 1'b1; btn_right = 1'b1;
    cyc();
    btn_left = 1'b0; btn_right = 1'b0;
    cyc();
    chk("both_edges", 32'(q_count), 32'd0);

    // game_en dropped during HOLD with a move still queued
    press_right();
    press_right();
    chk("abort_queued", 32'(q_count), 32'd2);
    do_tick(1'b1, 2'b10, 1'b1);
    game_en = 1'b0;
    cyc();
    chk("abort_lane", 32'(lane), 32'd0);
    chk("abort_q_count", 32'(q_count), 32'd0);
    press_left();
    chk("off_ignores_press", 32'(q_count), 32'd0);
    game_en = 1'b1;
    cyc();
    chk("reen_lane", 32'(lane), 32'd2);
    chk("reen_ovf_clear", 32'(overflow), 32'd0);

    // abort on the very tick that would pop: no pulse
    press_left();
    tick = 1'b1; game_en = 1'b0;
    cyc();
    tick = 1'b0;
    chk("tick_abort_mv", 32'(move_valid), 32'd0);
    chk("tick_abort_lane", 32'(lane), 32'd0);
    chk("tick_abort_q", 32'(q_count), 32'd0);
    game_en = 1'b1;
    cyc();
    chk("reen2_lane", 32'(lane), 32'd2);

`ifdef LANE_WRAP_EN
    press_left();
    do_tick(1'b1, 2'b01, 1'b0);
    do_tick(1'b0, 2'b00, 1'b0);
    press_left();
    do_tick(1'b1, 2'b11, 1'b0);
    chk("wrap_lane", 32'(lane), 32'd3);
`else
    press_right();
    do_tick(1'b1, 2'b11, 1'b1);
    do_tick(1'b0, 2'b00, 1'b0);
    press_right();
    do_tick(1'b0, 2'b00, 1'b0);
    chk("sat_right_lane", 32'(lane), 32'd3);
    chk("sat_right_q", 32'(q_count), 32'd0);
`endif

    cyc();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'(exp_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
